// File: rtl/ibex_rvfi_retire_fifo.sv
// ibex_rvfi_retire_fifo
//
// Purpose: captures every Ibex RVFI retirement beat into a small flop FIFO and
// replays it on a valid/ready stream for the power-analysis trace sink. The
// core cannot be back-pressured, so beats arriving while the FIFO is full
// (and not draining) are dropped and counted. The block also monitors
// rvfi_order continuity and raises a sticky error on any gap.
//
// Optional feature: define RVFI_TRACE_MEM_EN to store and replay the memory
// address and {wmask, rmask} of each beat. Without it, trace_mem_* are 0 and
// the rvfi_mem_* inputs are ignored.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rvfi_*_i             RVFI retirement beat (valid, order, pc, insn, trap,
//                        rd addr/data, mem addr/masks)
//   trace_valid_o/_ready_i  head-entry handshake to the trace sink
//   trace_*_o            head entry fields (0 while the FIFO is empty)
//   trace_level_o        occupancy 0..Depth
//   drop_cnt_o           saturating count of beats lost to overflow
//   order_err_o          sticky rvfi_order discontinuity flag
module ibex_rvfi_retire_fifo #(
    parameter int unsigned Depth    = 8,
    parameter int unsigned DropCntW = 16,
    localparam int unsigned LvlW    = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rvfi_valid_i,
    input  logic [63:0]         rvfi_order_i,
    input  logic [31:0]         rvfi_pc_rdata_i,
    input  logic [31:0]         rvfi_insn_i,
    input  logic                rvfi_trap_i,
    input  logic [4:0]          rvfi_rd_addr_i,
    input  logic [31:0]         rvfi_rd_wdata_i,
    input  logic [31:0]         rvfi_mem_addr_i,
    input  logic [3:0]          rvfi_mem_rmask_i,
    input  logic [3:0]          rvfi_mem_wmask_i,
    output logic                trace_valid_o,
    input  logic                trace_ready_i,
    output logic [31:0]         trace_pc_o,
    output logic [31:0]         trace_insn_o,
    output logic                trace_trap_o,
    output logic [4:0]          trace_rd_addr_o,
    output logic [31:0]         trace_rd_wdata_o,
    output logic [31:0]         trace_mem_addr_o,
    output logic [7:0]          trace_mem_mask_o,
    output logic [LvlW-1:0]     trace_level_o,
    output logic [DropCntW-1:0] drop_cnt_o,
    output logic                order_err_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;

    typedef enum logic {
        S_IDLE,
        S_TRACK
    } order_state_t;

    // Entry storage: data flops carry no reset; outputs are masked while empty.
    logic [31:0] r_pc    [Depth];
    logic [31:0] r_insn  [Depth];
    logic        r_trap  [Depth];
    logic [4:0]  r_rd    [Depth];
    logic [31:0] r_wdata [Depth];

    logic [PtrW-1:0]     r_wr_ptr;
    logic [PtrW-1:0]     r_rd_ptr;
    logic [DropCntW-1:0] r_drop_cnt;
    order_state_t        r_state;
    logic [63:0]         r_last_order;
    logic                r_order_err;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AddrW-1:0] w_wr_addr;
    logic [AddrW-1:0] w_rd_addr;

    assign w_wr_addr = r_wr_ptr[AddrW-1:0];
    assign w_rd_addr = r_rd_ptr[AddrW-1:0];
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]) &&
                       (w_wr_addr == w_rd_addr);
    assign w_pop     = !w_empty && trace_ready_i;
    // A same-cycle pop frees the slot, so a push on full is still accepted.
    assign w_push    = rvfi_valid_i && (!w_full || w_pop);
    assign w_drop    = rvfi_valid_i && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc[w_wr_addr]    <= rvfi_pc_rdata_i;
            r_insn[w_wr_addr]  <= rvfi_insn_i;
            r_trap[w_wr_addr]  <= rvfi_trap_i;
            r_rd[w_wr_addr]    <= rvfi_rd_addr_i;
            r_wdata[w_wr_addr] <= rvfi_rd_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // Order continuity: every beat counts, whether it was stored or dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_last_order <= '0;
            r_order_err  <= 1'b0;
        end else if (rvfi_valid_i) begin
            r_last_order <= rvfi_order_i;
            case (r_state)
                S_IDLE:  r_state <= S_TRACK;
                S_TRACK: if (rvfi_order_i != r_last_order + 64'd1) r_order_err <= 1'b1;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign trace_valid_o    = !w_empty;
    assign trace_pc_o       = w_empty ? '0   : r_pc[w_rd_addr];
    assign trace_insn_o     = w_empty ? '0   : r_insn[w_rd_addr];
    assign trace_trap_o     = w_empty ? 1'b0 : r_trap[w_rd_addr];
    assign trace_rd_addr_o  = w_empty ? '0   : r_rd[w_rd_addr];
    assign trace_rd_wdata_o = w_empty ? '0   : r_wdata[w_rd_addr];
    assign trace_level_o    = LvlW'(r_wr_ptr - r_rd_ptr);
    assign drop_cnt_o       = r_drop_cnt;
    assign order_err_o      = r_order_err;

`ifdef RVFI_TRACE_MEM_EN
    logic [31:0] r_maddr [Depth];
    logic [7:0]  r_mmask [Depth];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_maddr[w_wr_addr] <= rvfi_mem_addr_i;
            r_mmask[w_wr_addr] <= {rvfi_mem_wmask_i, rvfi_mem_rmask_i};
        end
    end

    assign trace_mem_addr_o = w_empty ? '0 : r_maddr[w_rd_addr];
    assign trace_mem_mask_o = w_empty ? '0 : r_mmask[w_rd_addr];
`else
    // Memory fields are not captured in this build.
    logic w_unused_mem;
    assign w_unused_mem     = ^{rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i};
    assign trace_mem_addr_o = '0;
    assign trace_mem_mask_o = '0;
`endif

endmodule

// File: tb/tb_ibex_rvfi_retire_fifo.sv
module tb_ibex_rvfi_retire_fifo;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rvfi_valid_i = 1'b0;
    logic [63:0] rvfi_order_i = '0;
    logic [31:0] rvfi_pc_rdata_i = '0;
    logic [31:0] rvfi_insn_i = '0;
    logic        rvfi_trap_i = 1'b0;
    logic [4:0]  rvfi_rd_addr_i = '0;
    logic [31:0] rvfi_rd_wdata_i = '0;
    logic [31:0] rvfi_mem_addr_i = '0;
    logic [3:0]  rvfi_mem_rmask_i = '0;
    logic [3:0]  rvfi_mem_wmask_i = '0;
    logic        trace_valid_o;
    logic        trace_ready_i = 1'b0;
    logic [31:0] trace_pc_o;
    logic [31:0] trace_insn_o;
    logic        trace_trap_o;
    logic [4:0]  trace_rd_addr_o;
    logic [31:0] trace_rd_wdata_o;
    logic [31:0] trace_mem_addr_o;
    logic [7:0]  trace_mem_mask_o;
    logic [3:0]  trace_level_o;
    logic [15:0] drop_cnt_o;
    logic        order_err_o;

    int n_pass = 0;
    int n_total = 0;
    logic [63:0] ord = '0;

    ibex_rvfi_retire_fifo #(.Depth(8), .DropCntW(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rvfi_valid_i(rvfi_valid_i), .rvfi_order_i(rvfi_order_i),
        .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_insn_i(rvfi_insn_i),
        .rvfi_trap_i(rvfi_trap_i), .rvfi_rd_addr_i(rvfi_rd_addr_i),
        .rvfi_rd_wdata_i(rvfi_rd_wdata_i), .rvfi_mem_addr_i(rvfi_mem_addr_i),
        .rvfi_mem_rmask_i(rvfi_mem_rmask_i), .rvfi_mem_wmask_i(rvfi_mem_wmask_i),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_pc_o(trace_pc_o), .trace_insn_o(trace_insn_o),
        .trace_trap_o(trace_trap_o), .trace_rd_addr_o(trace_rd_addr_o),
        .trace_rd_wdata_o(trace_rd_wdata_o), .trace_mem_addr_o(trace_mem_addr_o),
        .trace_mem_mask_o(trace_mem_mask_o), .trace_level_o(trace_level_o),
        .drop_cnt_o(drop_cnt_o), .order_err_o(order_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one contiguous-order beat for a single cycle.
    task automatic beat(input logic [31:0] pc);
        rvfi_valid_i    = 1'b1;
        rvfi_order_i    = ord;
        rvfi_pc_rdata_i = pc;
        rvfi_insn_i     = pc ^ 32'h0000_0013;
        tick();
        rvfi_valid_i    = 1'b0;
        ord             = ord + 64'd1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        ord    = '0;
        tick();
    endtask

    initial begin
        do_reset();
        chk("reset_valid", trace_valid_o, 0);
        chk("reset_level", trace_level_o, 0);

        // Reset in the middle of a stream with five entries stored.
        for (int i = 0; i < 5; i++) beat(32'h10 + 4 * i);
        chk("pre_rst_level", trace_level_o, 5);
        chk("pre_rst_valid", trace_valid_o, 1);
        chk("pre_rst_pc", trace_pc_o, 32'h10);
        rst_ni = 1'b0;
        #1;
        chk("rst_async_valid", trace_valid_o, 0);
        chk("rst_async_level", trace_level_o, 0);
        chk("rst_async_pc", trace_pc_o, 0);
        chk("rst_async_insn", trace_insn_o, 0);
        chk("rst_async_drop", drop_cnt_o, 0);
        chk("rst_async_err", order_err_o, 0);
        tick();
        rst_ni = 1'b1;
        ord = '0;
        tick();
        chk("post_rst_level", trace_level_o, 0);

        // Single beat, sink ready: visible for exactly one cycle.
        trace_ready_i   = 1'b1;
        rvfi_valid_i    = 1'b1;
        rvfi_order_i    = ord;
        rvfi_pc_rdata_i = 32'h100;
        rvfi_insn_i     = 32'h0050_0093;
        rvfi_rd_addr_i  = 5'd1;
        rvfi_rd_wdata_i = 32'd5;
        rvfi_trap_i     = 1'b1;
        #1;
        chk("one_lat0_valid", trace_valid_o, 0);
        tick();
        rvfi_valid_i = 1'b0;
        rvfi_trap_i  = 1'b0;
        ord = ord + 64'd1;
        chk("one_valid", trace_valid_o, 1);
        chk("one_pc", trace_pc_o, 32'h100);
        chk("one_insn", trace_insn_o, 32'h0050_0093);
        chk("one_rd", trace_rd_addr_o, 1);
        chk("one_wdata", trace_rd_wdata_o, 5);
        chk("one_trap", trace_trap_o, 1);
        chk("one_level", trace_level_o, 1);
        tick();
        chk("one_gone_valid", trace_valid_o, 0);
        chk("one_gone_level", trace_level_o, 0);

        // Overflow: ten beats into eight entries with the sink stalled.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) beat(32'(4 * i));
        chk("ovf_level", trace_level_o, 8);
        chk("ovf_drop", drop_cnt_o, 2);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_pc%0d", i), trace_pc_o, 32'(4 * i));
            chk($sformatf("drain_insn%0d", i), trace_insn_o, 32'(4 * i) ^ 32'h13);
            tick();
        end
        chk("drain_level", trace_level_o, 0);
        chk("drain_valid", trace_valid_o, 0);

        // Full FIFO with simultaneous pop and push: beat accepted, nothing dropped.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) beat(32'h40 + 4 * i);
        chk("full_level", trace_level_o, 8);
        chk("full_head", trace_pc_o, 32'h40);
        trace_ready_i = 1'b1;
        beat(32'h80);
        trace_ready_i = 1'b0;
        chk("pp_level", trace_level_o, 8);
        chk("pp_drop", drop_cnt_o, 2);
        chk("pp_head", trace_pc_o, 32'h44);
        chk("contig_err", order_err_o, 0);
        // Drain and confirm the accepted beat sits at the tail.
        trace_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("pp_tail_pc", trace_pc_o, 32'h80);
        tick();
        chk("pp_empty", trace_level_o, 0);

        // Order gap: 5, 6, 8.
        do_reset();
        ord = 64'd5;
        beat(32'h200);
        beat(32'h204);
        chk("ord_after6", order_err_o, 0);
        ord = 64'd8;
        rvfi_valid_i    = 1'b1;
        rvfi_order_i    = ord;
        #1;
        chk("ord_before_edge", order_err_o, 0);
        tick();
        rvfi_valid_i = 1'b0;
        ord = ord + 64'd1;
        chk("ord_after8", order_err_o, 1);
        beat(32'h20C);
        beat(32'h210);
        chk("ord_sticky", order_err_o, 1);
        do_reset();
        chk("ord_cleared", order_err_o, 0);

        // Memory fields.
        rvfi_mem_addr_i  = 32'h2000;
        rvfi_mem_wmask_i = 4'hF;
        rvfi_mem_rmask_i = 4'h0;
        trace_ready_i    = 1'b0;
        beat(32'h300);
`ifdef RVFI_TRACE_MEM_EN
        chk("mem_addr", trace_mem_addr_o, 32'h2000);
        chk("mem_mask", trace_mem_mask_o, 8'hF0);
`else
        chk("mem_addr", trace_mem_addr_o, 0);
        chk("mem_mask", trace_mem_mask_o, 0);
`endif
        chk("mem_pc", trace_pc_o, 32'h300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
